sdhci_obi_arbiter: RTL
======================

# sdhci_obi_arbiter

Round-robin arbiter that shares the single OBI subordinate port of the SDHCI register file between `NumReq` OBI managers, e.g. the host CPU and the SDHCI ADMA engine. It sits directly upstream of the SDHCI register block's OBI port. It allows exactly one outstanding transaction and routes each response back to the manager that issued the request. Requests pass through combinationally and are held stable while the downstream port stalls.

## Interface
- `NumReq`, default 2: number of upstream managers; legal range 2..8.
- `AddrWidth`, default 32: OBI address width.
- `DataWidth`, default 32: OBI data width.
- `IdWidth`, default 1: OBI `aid`/`rid` width; passed through unchanged.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `s_req_i`  in  NumReq  per-manager request.
- `s_gnt_o`  out  NumReq  per-manager grant.
- `s_addr_i`  in  NumReq×AddrWidth  address per manager.
- `s_we_i`  in  NumReq  write enable per manager.
- `s_be_i`  in  NumReq×DataWidth/8  byte enables per manager.
- `s_wdata_i`  in  NumReq×DataWidth  write data per manager.
- `s_aid_i`  in  NumReq×IdWidth  transaction ID per manager.
- `s_rvalid_o`  out  NumReq  response valid per manager.
- `s_rdata_o`  out  DataWidth  read data, shared across managers; qualified by `s_rvalid_o`.
- `s_err_o`  out  1  error, shared; qualified by `s_rvalid_o`.
- `s_rid_o`  out  IdWidth  response ID, shared; qualified by `s_rvalid_o`.
- `m_req_o`, `m_addr_o`, `m_we_o`, `m_be_o`, `m_wdata_o`, `m_aid_o`  out  request channel to the register block.
- `m_gnt_i`  in  1  downstream grant.
- `m_rvalid_i`, `m_rdata_i`, `m_err_i`, `m_rid_i`  in  response channel from the register block.

## Operation
- FSM states: IDLE, HOLD, RSP. Registers: `state`, `sel` (owner index, $clog2(NumReq) bits), `ptr` (round-robin priority pointer).
- Arbitration in IDLE:
  - `pick` is the first `i` with `s_req_i[i]=1`, scanning `ptr, ptr+1, …` modulo NumReq.
  - `m_req_o=1`; the `m_*` request fields are driven from manager `pick`.
  - `s_gnt_o[pick]=m_gnt_i`; all other grants are 0.
- IDLE transitions:
  - On `m_gnt_i`: `sel<=pick`, go to RSP.
  - Request present but no grant: `sel<=pick`, go to HOLD.
  - No request: stay in IDLE with `m_req_o=0`.
- HOLD:
  - The choice is frozen. Fields come from manager `sel` even if a higher-priority request arrives.
  - `s_gnt_o[sel]=m_gnt_i`; on `m_gnt_i` go to RSP.
  - OBI managers keep `req` high until granted, so dropping `s_req_i[sel]` in HOLD is illegal. The arbiter does not check this.
- RSP:
  - `m_req_o=0` and all `s_gnt_o=0`.
  - On `m_rvalid_i`: `s_rvalid_o[sel]=1` (combinational), `ptr<=(sel+1) mod NumReq`, go to IDLE.
- Response path:
  - `s_rdata_o=m_rdata_i`, `s_err_o=m_err_i` and `s_rid_o=m_rid_i` at all times.
  - Only `s_rvalid_o` is steered.
- `m_rvalid_i` in IDLE or HOLD is a protocol violation. It is ignored: no `s_rvalid_o` asserts.
- `m_err_i` passes through as-is. The arbiter itself never generates errors.

## Timing
- Reset (`rst_i=1` at a clock edge):
  - `state=IDLE`, `sel=0`, `ptr=0`.
  - During reset all outputs are forced to 0: `m_req_o`, `s_gnt_o`, `s_rvalid_o`.
- Reset mid-transaction: any pending response is dropped. The downstream block is reset in the same cycle.
- Request latency: 0 cycles. A request seen in IDLE reaches `m_req_o` in the same cycle, and `m_gnt_i` returns the same cycle.
- Response latency: 0 cycles added.
- Minimum transaction, for a downstream that grants immediately and responds on the next cycle:
  - Cycle n: IDLE, req/gnt.
  - Cycle n+1: RSP, rvalid.
  - Cycle n+2: IDLE, next request can be granted.
  - Peak rate is one transaction per 2 cycles.
- No grant is issued in the cycle a response is delivered.
- Simultaneous events:
  - All managers requesting: grants rotate strictly. With `ptr=k`, manager k wins and the next winner is k+1 mod NumReq.
  - Wrap-around at NumReq-1 returns to 0.
- `ptr` updates only on response completion, never on a grant alone.

## Test plan
- Single read: manager 0 requests address 0x24 with `m_gnt_i=1` and the response 1 cycle later with rdata 0xDEADBEEF → `s_gnt_o=01` at cycle 0, `s_rvalid_o=01` with `s_rdata_o=0xDEADBEEF` at cycle 1, `s_rvalid_o[1]` stays 0.
- Contention: both managers hold req continuously, 4 transactions → grant order 0,1,0,1; each grant lands 2 cycles after the previous one; `s_rid_o` matches each `aid`.
- Downstream stall: manager 1 alone, `m_gnt_i` low for 3 cycles while manager 0 asserts on cycle 1 → FSM stays in HOLD, `m_addr_o` stays manager 1's address, the grant goes to 1, then manager 0 is served next.
- Error and ID pass-through: manager 1 writes with aid=1 and the downstream responds `err=1` → `s_rvalid_o=10`, `s_err_o=1`, `s_rid_o=1`; `ptr` becomes 0.
- Blocking in RSP: a new request arrives while a response is pending for 5 cycles → `m_req_o=0` and `s_gnt_o=0` throughout, grant in the cycle after rvalid.
- Reset mid-op: `rst_i` pulsed in RSP → next cycle IDLE, `ptr=0`, a late `m_rvalid_i` produces no `s_rvalid_o`.

Source files
------------

// File: rtl/sdhci_obi_arbiter.sv
// Round-robin OBI arbiter in front of the SDHCI register block: one outstanding
// transaction, combinational request pass-through, response steered to its owner.
module sdhci_obi_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    s_req_i,
  output logic [NumReq-1:0]                    s_gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]     s_addr_i,
  input  logic [NumReq-1:0]                    s_we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   s_be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     s_wdata_i,
  input  logic [NumReq-1:0][IdWidth-1:0]       s_aid_i,
  output logic [NumReq-1:0]                    s_rvalid_o,
  output logic [DataWidth-1:0]                 s_rdata_o,
  output logic                                 s_err_o,
  output logic [IdWidth-1:0]                   s_rid_o,
  output logic                                 m_req_o,
  output logic [AddrWidth-1:0]                 m_addr_o,
  output logic                                 m_we_o,
  output logic [DataWidth/8-1:0]               m_be_o,
  output logic [DataWidth-1:0]                 m_wdata_o,
  output logic [IdWidth-1:0]                   m_aid_o,
  input  logic                                 m_gnt_i,
  input  logic                                 m_rvalid_i,
  input  logic [DataWidth-1:0]                 m_rdata_i,
  input  logic                                 m_err_i,
  input  logic [IdWidth-1:0]                   m_rid_i
);

  localparam int unsigned SelW = $clog2(NumReq);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [SelW-1:0]   ptr_q, ptr_d;
  logic [SelW-1:0]   pick;
  logic              pick_valid;
  logic [SelW-1:0]   owner;

  // First requester at or after the priority pointer, wrapping modulo NumReq.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      logic [SelW-1:0] cand;
      cand = SelW'((32'(ptr_q) + i) % NumReq);
      if (!pick_valid && s_req_i[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    owner      = sel_q;
    m_req_o    = 1'b0;
    s_gnt_o    = '0;
    s_rvalid_o = '0;

    unique case (state_q)
      IDLE: begin
        owner = pick;
        if (pick_valid) begin
          m_req_o       = 1'b1;
          s_gnt_o[pick] = m_gnt_i;
          sel_d         = pick;
          state_d       = m_gnt_i ? RSP : HOLD;
        end
      end
      // Choice stays frozen until the downstream grants.
      HOLD: begin
        m_req_o        = 1'b1;
        s_gnt_o[sel_q] = m_gnt_i;
        if (m_gnt_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (m_rvalid_i) begin
          s_rvalid_o[sel_q] = 1'b1;
          ptr_d   = (sel_q == SelW'(NumReq - 1)) ? '0 : sel_q + SelW'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst_i) begin
      m_req_o    = 1'b0;
      s_gnt_o    = '0;
      s_rvalid_o = '0;
    end
  end

  assign m_addr_o  = s_addr_i[owner];
  assign m_we_o    = s_we_i[owner];
  assign m_be_o    = s_be_i[owner];
  assign m_wdata_o = s_wdata_i[owner];
  assign m_aid_o   = s_aid_i[owner];

  assign s_rdata_o = m_rdata_i;
  assign s_err_o   = m_err_i;
  assign s_rid_o   = m_rid_i;

endmodule
